// File: rtl/arb_pkg.sv
// Shared types and default constants for the handshake arbiter slice.
// The watchdog is only built when ARB_WATCHDOG_EN is defined.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int ARB_N       = 4;
    localparam int ARB_DW      = 32;
    localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from (last+1) mod N and returns
// the first requester as a one-hot winner, plus a found flag.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = ARB_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  winner,
    output logic          found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[IW'(idx)]) begin
                winner[IW'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_arbiter.sv
// N-master to one-slave valid/ready arbiter with round-robin ownership.
// Define ARB_WATCHDOG_EN to add a TIMEOUT-cycle ownership watchdog.
module handshake_arbiter
    import arb_pkg::*;
#(
    parameter int N       = ARB_N,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]  in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [N-1:0]  grant,
    output logic          timeout_err,
    output logic          proto_err
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 8 || DW < 1 || TIMEOUT < 1) begin : g_param_check
        $error("handshake_arbiter: parameter out of range");
    end

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          proto_err_q, proto_err_d;
    logic [IW-1:0] owner;
    logic [N-1:0]  pick;
    logic          pick_found;
    logic          handshake;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_q, wd_d;
    logic          timeout_err_q, timeout_err_d;
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    rr_pick #(.N(N)) u_rr_pick (
        .req    (in_valid),
        .last   (last_q),
        .winner (pick),
        .found  (pick_found)
    );

    // grant_q is zero in IDLE, so the datapath needs no explicit state decode.
    always_comb begin
        owner    = '0;
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                owner = IW'(i);
            end
            if (grant_q[i] && in_valid[i]) begin
                out_data = in_data[i*DW +: DW];
            end
        end
    end

    assign out_valid = |(grant_q & in_valid);
    assign in_ready  = grant_q & {N{out_ready}};
    assign grant     = grant_q;
    assign proto_err = proto_err_q;
    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        proto_err_d = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wd_d          = '0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWN;
                    grant_d = pick;
                end
            end
            OWN: begin
                if (handshake) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner;
                end else if (!in_valid[owner]) begin
                    // Abandoned request: rotation is not advanced.
                    state_d     = IDLE;
                    grant_d     = '0;
                    proto_err_d = 1'b1;
                end
`ifdef ARB_WATCHDOG_EN
                else if (wd_q == CW'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    last_d        = owner;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(N - 1);
            proto_err_q <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
`ifdef ARB_WATCHDOG_EN
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Self-checking bench for handshake_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_handshake_arbiter;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            timeout_err;
    logic            proto_err;

    int vectors     = 0;
    int miscompares = 0;

    handshake_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .grant       (grant),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge and stay stable until the next.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int m, input logic [DW-1:0] d);
        in_data[m*DW +: DW] = d;
    endtask

    // Behavioural model: ownership as an integer (-1 = nobody), last winner,
    // pending one-cycle error pulses. Compared at every falling edge, then
    // advanced with the inputs the DUT will sample at the next rising edge.
    initial begin
        int  m_owner;
        int  m_last;
        int  m_cnt;
        bit  m_perr;
        bit  m_terr;
        bit  m_live;
        bit  m_ov;
        logic [63:0] e_grant;
        logic [63:0] e_data;
        logic [63:0] e_ready;
        m_owner = -1;
        m_last  = N - 1;
        m_cnt   = 0;
        m_perr  = 0;
        m_terr  = 0;
        m_live  = 0;
        forever begin
            @(negedge clk);
            m_ov    = (m_owner >= 0) && (((in_valid >> m_owner) & 1) != 0);
            e_grant = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
            e_ready = (m_owner >= 0 && out_ready) ? (64'd1 << m_owner) : 64'd0;
            e_data  = m_ov ? 64'(DW'(in_data >> (m_owner * DW))) : 64'd0;
            if (m_live) begin
                check("model_grant", grant, e_grant);
                check("model_out_valid", out_valid, m_ov);
                check("model_out_data", out_data, e_data);
                check("model_in_ready", in_ready, e_ready);
                check("model_proto_err", proto_err, m_perr);
                check("model_timeout_err", timeout_err, m_terr);
            end
            if (!reset) begin
                m_live  = 1;
                m_owner = -1;
                m_last  = N - 1;
                m_cnt   = 0;
                m_perr  = 0;
                m_terr  = 0;
            end else if (m_live) begin
                m_perr = 0;
                m_terr = 0;
                if (m_owner < 0) begin
                    m_cnt = 0;
                    for (int k = 1; k <= N; k++) begin
                        int idx;
                        idx = (m_last + k) % N;
                        if (m_owner < 0 && ((in_valid >> idx) & 1) != 0) m_owner = idx;
                    end
                end else if (m_ov && out_ready) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_cnt   = 0;
                end else if (!m_ov) begin
                    m_perr  = 1;
                    m_owner = -1;
                    m_cnt   = 0;
                end else begin
`ifdef ARB_WATCHDOG_EN
                    m_cnt++;
                    if (m_cnt == TIMEOUT) begin
                        m_terr  = 1;
                        m_last  = m_owner;
                        m_owner = -1;
                        m_cnt   = 0;
                    end
`endif
                end
            end
        end
    end

    task automatic applyStimulus();
        logic [N-1:0] seq [5];
        int           thr;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

        reset = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        check("reset_grant", grant, 4'b0000);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 4'b0000);
        check("reset_proto_err", proto_err, 1'b0);
        check("reset_timeout_err", timeout_err, 1'b0);
        reset = 1'b1;
        step();

        // Single transfer from master 0.
        in_valid = 4'b0001; set_data(0, 32'h20220503); out_ready = 1'b1;
        step();
        check("single_grant", grant, 4'b0001);
        check("single_out_data", out_data, 32'h20220503);
        check("single_in_ready", in_ready, 4'b0001);
        check("single_out_valid", out_valid, 1'b1);
        step();
        in_valid = '0;
        check("single_back_idle", grant, 4'b0000);

        // All masters busy from a fresh reset: strict rotation.
        reset = 1'b0;
        step();
        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int m = 0; m < N; m++) set_data(m, 32'hA000_0000 + m);
        for (int j = 0; j < 5; j++) begin
            step();
            check("rotate_grant", grant, seq[j]);
            check("rotate_in_ready", in_ready, seq[j]);
            step();
            check("rotate_gap", grant, 4'b0000);
        end
        in_valid = '0;

        // Backpressure on master 2.
        in_valid = 4'b0100; set_data(2, 32'h10000006); out_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check("stall_grant", grant, 4'b0100);
            check("stall_out_data", out_data, 32'h10000006);
            check("stall_in_ready", in_ready, 4'b0000);
            if (c < 4) step();
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", in_ready, 4'b0100);
        step();
        check("stall_done", grant, 4'b0000);
        in_valid = '0;

        // Owner withdraws its request.
        in_valid = 4'b1000; set_data(3, 32'h0BAD_F00D); out_ready = 1'b0;
        step();
        check("drop_grant", grant, 4'b1000);
        in_valid = 4'b0000;
        #1;
        check("drop_out_data_zero", out_data, 32'h0);
        check("drop_out_valid", out_valid, 1'b0);
        step();
        check("drop_idle", grant, 4'b0000);
        check("drop_proto_pulse", proto_err, 1'b1);
        in_valid = 4'b1000;
        step();
        check("drop_proto_end", proto_err, 1'b0);
        check("drop_regrant", grant, 4'b1000);
        out_ready = 1'b1;
        step();
        in_valid = '0;

        // Slave stuck not-ready.
        in_valid = 4'b0110; set_data(1, 32'h1111_1111); set_data(2, 32'h2222_2222); out_ready = 1'b0;
        step();
        check("stuck_grant", grant, 4'b0010);
`ifdef ARB_WATCHDOG_EN
        repeat (15) begin
            step();
            check("wd_hold", grant, 4'b0010);
            check("wd_quiet", timeout_err, 1'b0);
        end
        step();
        check("wd_release", grant, 4'b0000);
        check("wd_pulse", timeout_err, 1'b1);
        step();
        check("wd_next_owner", grant, 4'b0100);
        check("wd_pulse_end", timeout_err, 1'b0);
`else
        repeat (20) begin
            step();
            check("stuck_hold", grant, 4'b0010);
            check("stuck_no_timeout", timeout_err, 1'b0);
        end
`endif
        out_ready = 1'b1;
        step();
        in_valid = '0;
        check("stuck_done", grant, 4'b0000);

        // Reset during ownership.
        in_valid = 4'b1111; out_ready = 1'b0;
        step();
`ifdef ARB_WATCHDOG_EN
        check("midreset_owner", grant, 4'b1000);
`else
        check("midreset_owner", grant, 4'b0100);
`endif
        reset = 1'b0;
        step();
        check("midreset_grant", grant, 4'b0000);
        check("midreset_out_valid", out_valid, 1'b0);
        reset = 1'b1;
        step();
        check("midreset_priority", grant, 4'b0001);
        out_ready = 1'b1;
        step();
        in_valid = '0;
        step();

        // Randomized traffic; the model process does all checking here.
        for (int phase = 0; phase < 3; phase++) begin
            thr = (phase == 1) ? 1 : 7;
            for (int t = 0; t < 1500; t++) begin
                if (phase == 0 || $urandom_range(0, 15) == 0)
                    in_valid = N'($urandom);
                else
                    in_valid = in_valid | N'($urandom);
                for (int m = 0; m < N; m++) set_data(m, $urandom);
                out_ready = ($urandom_range(0, 9) < thr);
                reset     = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        reset = 1'b1; in_valid = '0;
        repeat (3) step();
    endtask

    task automatic checkOutput();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    initial begin
        applyStimulus();
        checkOutput();
    end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesting masters (2..8).
REQ-002 The block SHALL have parameter DW, default 32, giving the data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the watchdog limit in cycles (used only with ARB_WATCHDOG_EN).
REQ-004 The block SHALL have these ports, with clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- in_valid  in  N  per-master valid.
- in_data  in  N*DW  per-master data; master i occupies bits [i*DW +: DW].
- in_ready  out  N  per-master ready.
- out_valid  out  1  valid toward the shared slave.
- out_data  out  DW  data toward the shared slave.
- out_ready  in  1  ready from the shared slave.
- grant  out  N  one-hot current owner; all zero when idle.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.
- proto_err  out  1  one-cycle pulse when the granted master drops valid before its handshake.

Function
REQ-005 The block SHALL contain a two-state FSM with states IDLE and OWN.
REQ-006 In IDLE with any in_valid high, the block SHALL pick a winner round-robin, starting at (last+1) mod N. It SHALL register the one-hot grant and move to OWN on the next edge, giving one cycle of arbitration latency.
REQ-007 In IDLE, out_valid SHALL be 0, in_ready SHALL be all zero, and grant SHALL be all zero.
REQ-008 In OWN with owner g, the block SHALL drive out_valid = in_valid[g], out_data = in_data[g], in_ready[g] = out_ready, and in_ready[i] = 0 for every i != g. These paths SHALL be combinational, with no added latency.
REQ-009 A transfer SHALL occur on any edge where out_valid and out_ready are both 1. On that edge the block SHALL set last = g, clear grant and return to IDLE.
REQ-010 The grant SHALL never change while out_valid is 1 and out_ready is 0; the owner's data SHALL be presented unchanged until its handshake.
REQ-011 If in_valid[g] is 0 in OWN with no handshake, the block SHALL pulse proto_err for one cycle, return to IDLE and leave last unchanged.
REQ-012 Simultaneous requests SHALL be resolved strictly by rotation. Any master holding in_valid high SHALL be granted within N arbitrations.
REQ-013 The last pointer SHALL wrap from N-1 to 0.
REQ-014 out_data SHALL be all zero whenever out_valid is 0.

Reset
REQ-015 While reset is 0 at an edge, the block SHALL set state = IDLE, grant = 0, last = N-1 (so master 0 wins first), clear the watchdog count, and hold timeout_err = 0 and proto_err = 0.
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer; no handshake SHALL be reported on that edge.

Configuration
REQ-017 With macro ARB_WATCHDOG_EN defined, the block SHALL count cycles spent in OWN without a handshake.
- When the count reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle, set last = g, return to IDLE and clear the count.
- The count SHALL clear on every state change.
REQ-018 With ARB_WATCHDOG_EN undefined, the block SHALL contain no counter and SHALL tie timeout_err to 0; ownership lasts until handshake or proto_err.

Structure
REQ-019 A shared package arb_pkg SHALL hold the state enum (IDLE, OWN) and the default constants ARB_N = 4, ARB_DW = 32 and ARB_TIMEOUT = 16.
REQ-020 Round-robin selection SHALL be a sub-module rr_pick. It SHALL be purely combinational, taking the request vector and last pointer and returning the one-hot winner plus a found flag.

Verification
REQ-021 After reset release, master 0 presents in_valid with 32'h20220503 and out_ready is 1. Required: grant = 4'b0001 one cycle later, out_data = 32'h20220503, in_ready[0] = 1, transfer on that edge, then IDLE.
REQ-022 All four masters are valid continuously and out_ready is 1. Required: grant sequence 0001, 0010, 0100, 1000, 0001, with one transfer every 2 cycles.
REQ-023 Master 2 is granted with 32'h10000006 and out_ready is held 0 for 5 cycles. Required: grant stays 4'b0100, out_data stays stable and in_ready stays 0 for those cycles; the transfer occurs on the first cycle out_ready = 1.
REQ-024 The owner drops in_valid before its handshake. Required: proto_err = 1 for exactly one cycle, return to IDLE, and the same master wins again if it is the next in rotation.
REQ-025 With ARB_WATCHDOG_EN defined and out_ready stuck at 0: timeout_err pulses after 16 OWN cycles and the next valid master is granted. With the macro undefined: grant holds indefinitely and timeout_err stays 0.
REQ-026 reset is driven to 0 mid-OWN for one cycle. Required: grant = 0, out_valid = 0 on the next cycle, and master 0 has first priority afterward.
